piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out transmitter for the 8-bit serial link. It accepts a word through a valid/ready load handshake and emits it MSB-first, one bit per enabled cycle. Its `serial_out`/`bit_valid` pair drives the `data_in`/`shift_enable` inputs of the link's shift-register receiver directly, so a word sent here reassembles in the receiver with its original bit ordering. Back-to-back words stream with no idle gap, and an upstream `hold` input can stall transmission.

## Interface

Parameters:
- `WIDTH`, default 8: word length in bits. Must be ≥ 2.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset_n`  input  1  synchronous, active-low reset.
- `load_data`  input  WIDTH  word to transmit.
- `load_valid`  input  1  `load_data` is valid.
- `load_ready`  output  1  block can accept a word this cycle.
- `hold`  input  1  stall: freeze shifting this cycle.
- `serial_out`  output  1  current serial bit, MSB first.
- `bit_valid`  output  1  `serial_out` is valid this cycle; connects to the receiver's `shift_enable`.
- `bit_last`  output  1  current valid bit is bit 0 (the last) of the word.

## Operation

- Reset is synchronous and active-low, sampled on the rising edge of `clk`.
- Internal state:
  - FSM with states IDLE and SHIFT.
  - WIDTH-bit shift register `shreg`.
  - Bit counter `cnt`, `$clog2(WIDTH)` bits wide, counting 0..WIDTH-1 with no wrap beyond that.
- A load is accepted when `load_valid && load_ready` at a clock edge. On acceptance: `shreg <= load_data`, `cnt <= 0`, state goes to SHIFT.
- `load_ready`:
  - In IDLE: 1.
  - In SHIFT: 1 only when `cnt == WIDTH-1 && !hold`.
  - Otherwise: 0.
  - Forced to 0 while `reset_n` is low.
- In SHIFT:
  - Combinational outputs: `serial_out = shreg[WIDTH-1]`, `bit_valid = !hold`, `bit_last = !hold && cnt == WIDTH-1`.
- SHIFT, edge with `hold = 0`:
  - `shreg <= shreg << 1`, zero-filled.
  - `cnt <= cnt + 1`.
  - If `cnt == WIDTH-1`:
    - With a load accepted on the same edge, the load wins: reload and stay in SHIFT.
    - Otherwise go to IDLE.
- SHIFT, edge with `hold = 1`: `shreg`, `cnt` and the state are all unchanged.
- In IDLE: `serial_out = 0`, `bit_valid = 0`, `bit_last = 0`; `hold` is ignored.
- `load_valid` asserted while `load_ready = 0`: no effect. The word is not captured, and the upstream must keep holding it.
- Receiver pairing: WIDTH valid bits shifted into the receiver (`{q[WIDTH-2:0], d}`) reproduce `load_data` exactly.

## Timing

- Reset values:
  - Outputs: `serial_out = 0`, `bit_valid = 0`, `bit_last = 0`, `load_ready = 0` during reset, then 1 in the first cycle after release.
  - Internal: state IDLE, `shreg = 0`, `cnt = 0`.
- Latency:
  - A load accepted at edge N puts the MSB on `serial_out` with `bit_valid = 1` in the cycle after edge N (assuming `hold = 0`).
  - One word takes exactly WIDTH non-held cycles.
- Throughput: with `load_valid` held high and `hold` low, `bit_valid` stays high continuously. There is zero gap between words.
- `hold` is combinational to `bit_valid`, `bit_last` and `load_ready`, with no internal registering.
- Reset asserted mid-word:
  - The word in flight is discarded.
  - The block is in IDLE after the edge.
  - No partial bits are emitted afterwards.
- `hold` on the last bit: `load_ready` stays 0 until `hold` falls, so a pending load is accepted on the same edge as the last bit completes.

## Test plan

- **Reset:** hold `reset_n = 0` for 3 cycles, then release. Expect all outputs 0 during reset and `load_ready = 1` in the first cycle after release.
- **Single word:** load 0xA5 with `hold = 0`.
  - `serial_out` is 1,0,1,0,0,1,0,1 on cycles 1–8 with `bit_valid = 1`.
  - `bit_last = 1` only on cycle 8.
  - IDLE on cycle 9.
  - A model receiver fed from this block reads 0xA5.
- **Back-to-back:** load 0x3C, then keep 0xC3 pending.
  - 0xC3 is accepted on the edge of 0x3C's last bit.
  - 16 contiguous `bit_valid` cycles: 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1.
  - Receiver reads 0x3C, then 0xC3.
- **Hold mid-word:** load 0xF0 and assert `hold` for 3 cycles after bit 2.
  - `bit_valid = 0` and `serial_out` frozen during the hold.
  - The bit sequence resumes unchanged; receiver reads 0xF0 after 11 cycles total.
- **Busy load:** assert `load_valid` with 0x55 while 0xFF is mid-word. Expect 0x55 to be ignored until the last bit of 0xFF, and the receiver to read 0xFF then 0x55.
- **Reset mid-word:** pulse `reset_n` low after bit 4 of 0x81. Expect `bit_valid = 0` immediately after the edge, IDLE, and no further bits.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Load handshake, stall input and serial bit stream of the PISO transmitter.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             hold;
    logic             serial_out;
    logic             bit_valid;
    logic             bit_last;

    // Upstream side: supplies words and the stall request, observes the stream.
    modport master (
        output load_data,
        output load_valid,
        output hold,
        input  load_ready,
        input  serial_out,
        input  bit_valid,
        input  bit_last
    );

    // Transmitter side.
    modport slave (
        input  load_data,
        input  load_valid,
        input  hold,
        output load_ready,
        output serial_out,
        output bit_valid,
        output bit_last
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word over valid/ready and
// shifts it out MSB-first, one bit per non-held cycle, with back-to-back
// words streaming without an idle gap.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    piso_serializer_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic               last_bit;
    logic               load_ready;
    logic               accept;

    // Last bit of the word is on the line (independent of hold).
    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

    // Ready is combinational on hold so a pending word is taken on the very
    // edge that completes the last bit; never ready while reset is asserted.
    assign load_ready = reset_n && ((state_q == IDLE) || (last_bit && !bus.hold));
    assign accept     = bus.load_valid && load_ready;

    // Serial outputs are only meaningful in SHIFT; IDLE drives zeros.
    assign bus.load_ready = load_ready;
    assign bus.serial_out = (state_q == SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
    assign bus.bit_valid  = (state_q == SHIFT) && !bus.hold;
    assign bus.bit_last   = last_bit && !bus.hold;

    // Next-state logic: load, shift, or freeze on hold.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = bus.load_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!bus.hold) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // A word waiting on the final edge takes over with no gap.
                        if (accept) begin
                            shreg_d = bus.load_data;
                            cnt_d   = '0;
                            state_d = SHIFT;
                        end else begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; a word in flight is dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus a
// randomized run against a bit-queue reference model.
module tb_piso_serializer;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    piso_serializer_if #(.WIDTH(WIDTH)) dut_if();

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dut_if)
    );

    always #5 clk = ~clk;

    // Model of the link's shift-register receiver.
    logic [7:0] rx = 8'h00;
    always @(posedge clk) begin
        if (dut_if.bit_valid) rx <= {rx[6:0], dut_if.serial_out};
    end

    // Observed vector: {serial_out, bit_valid, bit_last, load_ready}.
    logic [3:0] obs;
    assign obs = {dut_if.serial_out, dut_if.bit_valid, dut_if.bit_last, dut_if.load_ready};

    task automatic next_cycle(input logic lv, input logic [7:0] ld, input logic h, input logic rn);
        @(negedge clk);
        dut_if.load_valid = lv;
        dut_if.load_data  = ld;
        dut_if.hold       = h;
        reset_n           = rn;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            next_cycle(1'b0, 8'h00, 1'b0, 1'b0);
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outputs[%0d] got=%b exp=0000", i, obs);
            end
        end
        next_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if (obs !== 4'b0001) begin
            bad++;
            $display("FAIL reset_release got=%b exp=0001", obs);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w = 8'hA5;
        logic [3:0] e;
        next_cycle(1'b1, w, 1'b0, 1'b1);
        total++;
        if (obs !== 4'b0001) begin
            bad++;
            $display("FAIL single_accept got=%b exp=0001", obs);
        end
        for (int i = 0; i < 8; i++) begin
            next_cycle(1'b0, 8'h00, 1'b0, 1'b1);
            e = {w[7-i], 1'b1, (i == 7), (i == 7)};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL single_bit[%0d] got=%b exp=%b", i, obs, e);
            end
        end
        next_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if (obs !== 4'b0001) begin
            bad++;
            $display("FAIL single_idle got=%b exp=0001", obs);
        end
        total++;
        if (rx !== w) begin
            bad++;
            $display("FAIL single_rx got=%h exp=%h", rx, w);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w = 16'h3CC3;
        logic [3:0]  e;
        logic        lst;
        next_cycle(1'b1, 8'h3C, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            next_cycle((i < 8), 8'hC3, 1'b0, 1'b1);
            lst = (i == 7) || (i == 15);
            e = {w[15-i], 1'b1, lst, lst};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL b2b_bit[%0d] got=%b exp=%b", i, obs, e);
            end
            if (i == 8) begin
                total++;
                if (rx !== 8'h3C) begin
                    bad++;
                    $display("FAIL b2b_rx_first got=%h exp=3c", rx);
                end
            end
        end
        next_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if (obs !== 4'b0001) begin
            bad++;
            $display("FAIL b2b_idle got=%b exp=0001", obs);
        end
        total++;
        if (rx !== 8'hC3) begin
            bad++;
            $display("FAIL b2b_rx_second got=%h exp=c3", rx);
        end
    endtask

    task automatic test_hold_mid_word();
        logic [7:0] w = 8'hF0;
        logic [3:0] e;
        logic       h;
        int         b = 0;
        next_cycle(1'b1, w, 1'b0, 1'b1);
        for (int j = 0; j < 11; j++) begin
            h = (j >= 2) && (j <= 4);
            next_cycle(1'b0, 8'h00, h, 1'b1);
            e = {w[7-b], !h, (!h && b == 7), (!h && b == 7)};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL hold_cycle[%0d] got=%b exp=%b", j, obs, e);
            end
            if (!h) b++;
        end
        next_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if (rx !== w) begin
            bad++;
            $display("FAIL hold_rx got=%h exp=%h", rx, w);
        end
    endtask

    task automatic test_busy_load();
        logic [15:0] w = 16'hFF55;
        logic [3:0]  e;
        logic        lst;
        next_cycle(1'b1, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            next_cycle((i >= 2 && i <= 7), 8'h55, 1'b0, 1'b1);
            lst = (i == 7) || (i == 15);
            e = {w[15-i], 1'b1, lst, lst};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL busy_bit[%0d] got=%b exp=%b", i, obs, e);
            end
            if (i == 8) begin
                total++;
                if (rx !== 8'hFF) begin
                    bad++;
                    $display("FAIL busy_rx_first got=%h exp=ff", rx);
                end
            end
        end
        next_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if (rx !== 8'h55) begin
            bad++;
            $display("FAIL busy_rx_second got=%h exp=55", rx);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w = 8'h81;
        logic [3:0] e;
        next_cycle(1'b1, w, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            next_cycle(1'b0, 8'h00, 1'b0, 1'b1);
            e = {w[7-i], 1'b1, 1'b0, 1'b0};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL rstmid_bit[%0d] got=%b exp=%b", i, obs, e);
            end
        end
        next_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        total++;
        if (obs !== {w[3], 3'b100}) begin
            bad++;
            $display("FAIL rstmid_during got=%b exp=%b", obs, {w[3], 3'b100});
        end
        for (int i = 0; i < 5; i++) begin
            next_cycle(1'b0, 8'h00, 1'b0, 1'b1);
            total++;
            if (obs !== 4'b0001) begin
                bad++;
                $display("FAIL rstmid_after[%0d] got=%b exp=0001", i, obs);
            end
        end
    endtask

    task automatic test_random();
        logic       exp_q[$];
        logic [7:0] words[$];
        logic [7:0] pdata = 8'h00;
        logic [7:0] rx_exp = 8'h00;
        logic       pending = 1'b0;
        logic       rx_due = 1'b0;
        logic       h;
        logic       ready_e;
        logic [3:0] e;
        int         popped = 0;
        int         sz;
        for (int c = 0; c < 400; c++) begin
            if (!pending && $urandom_range(0, 2) != 0) begin
                pending = 1'b1;
                pdata   = 8'($urandom);
            end
            h = ($urandom_range(0, 3) == 0);
            next_cycle(pending, pdata, h, 1'b1);
            if (rx_due) begin
                rx_due = 1'b0;
                total++;
                if (rx !== rx_exp) begin
                    bad++;
                    $display("FAIL rand_rx[%0d] got=%h exp=%h", c, rx, rx_exp);
                end
            end
            sz      = exp_q.size();
            ready_e = (sz == 0) || (sz == 1 && !h);
            e = {(sz > 0) ? exp_q[0] : 1'b0, (sz > 0 && !h), (sz == 1 && !h), ready_e};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL rand_cycle[%0d] got=%b exp=%b", c, obs, e);
            end
            if (sz > 0 && !h) begin
                void'(exp_q.pop_front());
                popped++;
                if (popped == 8) begin
                    popped = 0;
                    rx_exp = words.pop_front();
                    rx_due = 1'b1;
                end
            end
            if (pending && ready_e) begin
                for (int k = 7; k >= 0; k--) exp_q.push_back(pdata[k]);
                words.push_back(pdata);
                pending = 1'b0;
            end
        end
    endtask

    initial begin
        dut_if.load_valid = 1'b0;
        dut_if.load_data  = 8'h00;
        dut_if.hold       = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_hold_mid_word();
        test_busy_load();
        test_reset_mid_word();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
